// File: rtl/sub_pkg.sv
// Shared types and helpers for the multicycle subtractor.
// Holds the FSM state type and the digit-count function.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sub_state_t;

    function automatic int sub_ndig(input int w, input int d);
        return w / d;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational D-bit ripple-borrow subtract slice: {bo,d} = x - y - bi.
// Ports: x, y (D-bit operands), bi (borrow in), d (D-bit difference), bo (borrow out).
module sub_digit #(
    parameter int D = 1
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         bi,
    output logic [D-1:0] d,
    output logic         bo
);

    logic [D:0] s;

    // One extra bit catches the borrow as the sign of the slice result.
    assign s  = {1'b0, x} - {1'b0, y} - {{D{1'b0}}, bi};
    assign d  = s[D-1:0];
    assign bo = s[D];

endmodule

// File: rtl/multicycle_subtractor.sv
// W-bit unsigned a - b - bin, D bits per clock, LSB digit first.
// Ports: clk, rst (async high); in_valid/in_ready with a, b, bin;
//   out_valid/out_ready with diff, bout; busy while BUSY or DONE.
// Build option SUB_SATURATE_EN: diff floors to 0 when bout is set.
module multicycle_subtractor
    import sub_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         busy
);

    localparam int NDIG = sub_ndig(W, D);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (W < 1 || D < 1 || D > W || (W % D) != 0) begin : g_bad_cfg
            $error("multicycle_subtractor: need 1 <= D <= W and W %% D == 0");
        end
    endgenerate

    sub_state_t      state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    diff_sh_q, diff_sh_d;
    logic            brw_q, brw_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [D-1:0]    dig_d;
    logic            dig_bo;
    logic [W+D-1:0]  diff_cat;

    sub_digit #(.D(D)) u_digit (
        .x  (a_sh_q[D-1:0]),
        .y  (b_sh_q[D-1:0]),
        .bi (brw_q),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // New digit enters at the MSB end; works for D == W too.
    assign diff_cat = {dig_d, diff_sh_q};

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    brw_d     = bin;
                    diff_sh_d = '0;
                    cnt_d     = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                a_sh_d    = W'({{D{1'b0}}, a_sh_q} >> D);
                b_sh_d    = W'({{D{1'b0}}, b_sh_q} >> D);
                diff_sh_d = diff_cat[W+D-1:D];
                brw_d     = dig_bo;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            brw_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            brw_q     <= brw_d;
            cnt_q     <= cnt_d;
        end
    end

    // Results are exposed only in DONE so partial sums never leak out.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        bout      = out_valid & brw_q;
        diff      = out_valid ? diff_sh_q : '0;
`ifdef SUB_SATURATE_EN
        if (bout) begin
            diff = '0;
        end
`endif
    end

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Self-checking bench for multicycle_subtractor (W8/D2, W8/D8, W4/D1).
// Random and directed operations compared with an integer reference.
module tb_multicycle_subtractor;

    logic clk;
    logic rst;

    // W=8, D=2 instance
    logic       p_iv, p_ir, p_bin, p_ov, p_or, p_bout, p_busy;
    logic [7:0] p_a, p_b, p_diff;
    // W=8, D=8 instance
    logic       q_iv, q_ir, q_bin, q_ov, q_or, q_bout, q_busy;
    logic [7:0] q_a, q_b, q_diff;
    // W=4, D=1 instance
    logic       r_iv, r_ir, r_bin, r_ov, r_or, r_bout, r_busy;
    logic [3:0] r_a, r_b, r_diff;

    int n_chk;
    int n_fail;

    multicycle_subtractor #(.W(8), .D(2)) u_p (
        .clk(clk), .rst(rst), .in_valid(p_iv), .in_ready(p_ir),
        .a(p_a), .b(p_b), .bin(p_bin), .out_valid(p_ov),
        .out_ready(p_or), .diff(p_diff), .bout(p_bout), .busy(p_busy)
    );

    multicycle_subtractor #(.W(8), .D(8)) u_q (
        .clk(clk), .rst(rst), .in_valid(q_iv), .in_ready(q_ir),
        .a(q_a), .b(q_b), .bin(q_bin), .out_valid(q_ov),
        .out_ready(q_or), .diff(q_diff), .bout(q_bout), .busy(q_busy)
    );

    multicycle_subtractor #(.W(4), .D(1)) u_r (
        .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir),
        .a(r_a), .b(r_b), .bin(r_bin), .out_valid(r_ov),
        .out_ready(r_or), .diff(r_diff), .bout(r_bout), .busy(r_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed integer subtraction, wrapped into W bits.
    function automatic void ref_sub(input int w, input int x, input int y,
                                    input int bi, output int d, output bit bo);
        int v;
        v  = x - y - bi;
        bo = (v < 0);
        d  = bo ? v + (1 << w) : v;
`ifdef SUB_SATURATE_EN
        if (bo) d = 0;
`endif
    endfunction

    task automatic do_p(input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, output int lat,
                        output logic [7:0] od, output logic ob);
        @(negedge clk);
        p_a = ia; p_b = ib; p_bin = ibin; p_iv = 1'b1;
        @(posedge clk); #1;
        p_iv = 1'b0;
        lat = 0;
        while (!p_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        od = p_diff;
        ob = p_bout;
        p_or = 1'b1;
        @(posedge clk); #1;
        p_or = 1'b0;
    endtask

    task automatic do_q(input logic [7:0] ia, input logic [7:0] ib,
                        input logic ibin, output int lat,
                        output logic [7:0] od, output logic ob);
        @(negedge clk);
        q_a = ia; q_b = ib; q_bin = ibin; q_iv = 1'b1;
        @(posedge clk); #1;
        q_iv = 1'b0;
        lat = 0;
        while (!q_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        od = q_diff;
        ob = q_bout;
        q_or = 1'b1;
        @(posedge clk); #1;
        q_or = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({p_ir, p_ov, p_busy, p_bout, p_diff} !== {3'b100, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_p got ir/ov/busy/bout/diff=%b%b%b%b/%h want 1000/00",
                     p_ir, p_ov, p_busy, p_bout, p_diff);
        end
        n_chk++;
        if ({r_ir, r_ov, r_busy, r_bout, r_diff} !== {3'b100, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_r got ir/ov/busy/bout/diff=%b%b%b%b/%h want 1000/0",
                     r_ir, r_ov, r_busy, r_bout, r_diff);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, ed; bit eb;
        logic [7:0] d; logic bo;
        do_p(8'h5A, 8'h3C, 1'b0, lat, d, bo);
        ref_sub(8, 'h5A, 'h3C, 0, ed, eb);
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 4", lat);
        end
        n_chk++;
        if ({bo, d} !== {eb, 8'(ed)}) begin
            n_fail++;
            $display("FAIL basic_result got %b/%h want %b/%h", bo, d, eb, 8'(ed));
        end
    endtask

    task automatic test_underflow();
        int lat, ed; bit eb;
        logic [7:0] d; logic bo;
        do_p(8'h00, 8'h01, 1'b0, lat, d, bo);
        ref_sub(8, 0, 1, 0, ed, eb);
        n_chk++;
        if ({bo, d} !== {eb, 8'(ed)}) begin
            n_fail++;
            $display("FAIL underflow got %b/%h want %b/%h", bo, d, eb, 8'(ed));
        end
    endtask

    task automatic test_full_digit();
        int lat, ed; bit eb;
        logic [7:0] d; logic bo;
        do_q(8'hFF, 8'hFF, 1'b1, lat, d, bo);
        ref_sub(8, 'hFF, 'hFF, 1, ed, eb);
        n_chk++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL full_digit_latency got %0d want 1", lat);
        end
        n_chk++;
        if ({bo, d} !== {eb, 8'(ed)}) begin
            n_fail++;
            $display("FAIL full_digit_result got %b/%h want %b/%h", bo, d, eb, 8'(ed));
        end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] x, y; logic c;
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            do_q(x, y, c, lat, d, bo);
            ref_sub(8, int'(x), int'(y), int'(c), ed, eb);
            n_chk++;
            if ({bo, d} !== {eb, 8'(ed)} || lat !== 1) begin
                n_fail++;
                $display("FAIL full_digit_rand %h-%h-%b got %b/%h lat %0d want %b/%h lat 1",
                         x, y, c, bo, d, lat, eb, 8'(ed));
            end
        end
    endtask

    task automatic test_random();
        int lat, ed; bit eb;
        logic [7:0] d; logic bo;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x, y; logic c;
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            if (i == 0) begin x = 8'h80; y = 8'h80; c = 1'b0; end
            if (i == 1) begin x = 8'h00; y = 8'hFF; c = 1'b1; end
            do_p(x, y, c, lat, d, bo);
            ref_sub(8, int'(x), int'(y), int'(c), ed, eb);
            n_chk++;
            if ({bo, d} !== {eb, 8'(ed)} || lat !== 4) begin
                n_fail++;
                $display("FAIL random %h-%h-%b got %b/%h lat %0d want %b/%h lat 4",
                         x, y, c, bo, d, lat, eb, 8'(ed));
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, ed; bit eb;
        @(negedge clk);
        p_a = 8'hC3; p_b = 8'h41; p_bin = 1'b1; p_iv = 1'b1;
        ref_sub(8, 'hC3, 'h41, 1, ed, eb);
        @(posedge clk); #1;
        p_iv = 1'b0;
        lat = 0;
        while (!p_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            p_iv = 1'($urandom);
            p_a  = 8'($urandom);
            p_b  = 8'($urandom);
            @(posedge clk); #1;
            n_chk++;
            if ({p_ov, p_ir, p_bout, p_diff} !== {2'b10, eb, 8'(ed)}) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc %0d got ov/ir=%b%b %b/%h want 10 %b/%h",
                         i, p_ov, p_ir, p_bout, p_diff, eb, 8'(ed));
            end
        end
        p_iv = 1'b0;
        p_or = 1'b1;
        #1;
        n_chk++;
        if (p_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL done_no_overlap in_ready got %b want 0", p_ir);
        end
        @(posedge clk); #1;
        p_or = 1'b0;
        n_chk++;
        if ({p_ov, p_ir, p_busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL release got ov/ir/busy=%b%b%b want 010", p_ov, p_ir, p_busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ed; bit eb;
        logic [7:0] d; logic bo;
        @(negedge clk);
        p_a = 8'h10; p_b = 8'h20; p_bin = 1'b0; p_iv = 1'b1;
        @(posedge clk); #1;
        p_iv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({p_ir, p_ov, p_busy, p_bout, p_diff} !== {3'b100, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid got ir/ov/busy/bout/diff=%b%b%b%b/%h want 1000/00",
                     p_ir, p_ov, p_busy, p_bout, p_diff);
        end
        @(negedge clk);
        rst = 1'b0;
        do_p(8'h9E, 8'h27, 1'b1, lat, d, bo);
        ref_sub(8, 'h9E, 'h27, 1, ed, eb);
        n_chk++;
        if ({bo, d} !== {eb, 8'(ed)} || lat !== 4) begin
            n_fail++;
            $display("FAIL after_reset got %b/%h lat %0d want %b/%h lat 4",
                     bo, d, lat, eb, 8'(ed));
        end
    endtask

    task automatic test_exhaustive();
        int ed, lat, hold; bit eb;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    r_a = 4'(x); r_b = 4'(y); r_bin = 1'(c); r_iv = 1'b1;
                    @(posedge clk); #1;
                    r_iv = 1'b0;
                    lat = 0;
                    while (!r_ov && lat < 40) begin
                        r_or = 1'($urandom);
                        @(posedge clk); #1;
                        lat++;
                    end
                    ref_sub(4, x, y, c, ed, eb);
                    n_chk++;
                    if ({r_bout, r_diff} !== {eb, 4'(ed)} || lat !== 4) begin
                        n_fail++;
                        $display("FAIL sweep %h-%h-%0d got %b/%h lat %0d want %b/%h lat 4",
                                 x, y, c, r_bout, r_diff, lat, eb, 4'(ed));
                    end
                    hold = 0;
                    while (r_ov && hold < 60) begin
                        r_or = 1'($urandom);
                        @(posedge clk); #1;
                        hold++;
                    end
                    r_or = 1'b0;
                    if (hold >= 60) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sweep_drain timeout got out_valid=%b want 0", r_ov);
                    end
                end
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        p_iv = 1'b0; p_or = 1'b0; p_a = '0; p_b = '0; p_bin = 1'b0;
        q_iv = 1'b0; q_or = 1'b0; q_a = '0; q_b = '0; q_bin = 1'b0;
        r_iv = 1'b0; r_or = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_full_digit();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
